exec_trace_buffer: RTL and testbench

EXEC_TRACE_BUFFER -- requirements
Module: exec_trace_buffer

---
 rtl/exec_trace_buffer_if.sv | 28 ++
 rtl/exec_trace_buffer.sv | 122 ++++++++++++
 tb/tb_exec_trace_buffer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_trace_buffer_if.sv
// Trace bus for exec_trace_buffer: per-step CPU capture fields plus the
// combinational readback port.
`timescale 1ns/1ps
interface exec_trace_buffer_if #(
    parameter int PC_W = 9
);
    logic [PC_W-1:0] pc_in;
    logic [31:0]     instr_in;
    logic            reg_we_in;
    logic [4:0]      reg_waddr_in;
    logic [31:0]     reg_wdata_in;
    logic [3:0]      rd_idx;
    logic [1:0]      rd_sel;
    logic [31:0]     rd_data;
    logic            rd_valid;

    modport master (
        output pc_in, instr_in, reg_we_in, reg_waddr_in, reg_wdata_in,
        output rd_idx, rd_sel,
        input  rd_data, rd_valid
    );

    modport slave (
        input  pc_in, instr_in, reg_we_in, reg_waddr_in, reg_wdata_in,
        input  rd_idx, rd_sel,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/exec_trace_buffer.sv
// Circular execution trace buffer with PC breakpoint trigger, post-trigger
// capture window and freeze; newest-first combinational readback.
`timescale 1ns/1ps
module exec_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int PC_W  = 9
) (
    input  logic                hand_clock,
    input  logic                reset,
    exec_trace_buffer_if.slave  bus,
    input  logic                arm,
    input  logic                bp_en,
    input  logic [PC_W-1:0]     bp_pc,
    input  logic [3:0]          post_count,
    output logic [1:0]          state_out,
    output logic [4:0]          count_out,
    output logic                triggered
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        POST    = 2'b10,
        FROZEN  = 2'b11
    } state_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic            we;
        logic [4:0]      waddr;
        logic [31:0]     wdata;
    } entry_t;

    state_e          state_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [4:0]      count_q;
    logic [3:0]      remaining_q;
    logic            triggered_q;
    entry_t          mem_q [DEPTH];

    logic            wr_en;
    logic            bp_hit;
    entry_t          entry_d;
    logic [AW-1:0]   rd_addr;
    entry_t          rd_entry;

    // arm wins over everything, so it also suppresses the write on its edge.
    assign wr_en  = !arm && (state_q == CAPTURE || state_q == POST);
    assign bp_hit = bp_en && (bus.pc_in == bp_pc);

    assign entry_d = '{pc:    bus.pc_in,
                       instr: bus.instr_in,
                       we:    bus.reg_we_in,
                       waddr: bus.reg_waddr_in,
                       wdata: bus.reg_wdata_in};

    always_ff @(posedge hand_clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            triggered_q <= 1'b0;
        end else if (arm) begin
            state_q     <= CAPTURE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            triggered_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                if (count_q != 5'(DEPTH)) count_q <= count_q + 5'd1;
            end
            case (state_q)
                CAPTURE: begin
                    if (bp_hit) begin
                        triggered_q <= 1'b1;
                        if (post_count == 4'd0) begin
                            state_q <= FROZEN;
                        end else begin
                            state_q     <= POST;
                            remaining_q <= post_count;
                        end
                    end
                end
                // Breakpoint matches are deliberately ignored here.
                POST: begin
                    remaining_q <= remaining_q - 4'd1;
                    if (remaining_q == 4'd1) state_q <= FROZEN;
                end
                default: ;
            endcase
        end
    end

    // NOTE: trace storage has no reset; count_q == 0 already masks stale entries.
    always_ff @(posedge hand_clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= entry_d;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_addr      = wr_ptr_q - AW'(1) - AW'(bus.rd_idx);
        rd_entry     = mem_q[rd_addr];
        bus.rd_valid = ({1'b0, bus.rd_idx} < count_q);
        bus.rd_data  = '0;
        if (bus.rd_valid) begin
            case (bus.rd_sel)
                2'b00:   bus.rd_data = 32'(rd_entry.pc);
                2'b01:   bus.rd_data = rd_entry.instr;
                2'b10:   bus.rd_data = rd_entry.wdata;
                default: bus.rd_data = {26'b0, rd_entry.we, rd_entry.waddr};
            endcase
        end
    end

    assign state_out = state_q;
    assign count_out = count_q;
    assign triggered = triggered_q;
endmodule

// File: tb/tb_exec_trace_buffer.sv
// Scoreboard bench for exec_trace_buffer: stimulus queues expected readback and
// status values, a monitor compares them whenever a probe strobe is raised.
`timescale 1ns/1ps
module tb_exec_trace_buffer;
    logic       hand_clock;
    logic       reset;
    logic       arm;
    logic       bp_en;
    logic [8:0] bp_pc;
    logic [3:0] post_count;
    logic [1:0] state_out;
    logic [4:0] count_out;
    logic       triggered;
    logic       probe;

    exec_trace_buffer_if #(.PC_W(9)) bus ();

    exec_trace_buffer #(.DEPTH(16), .PC_W(9)) dut (
        .hand_clock (hand_clock),
        .reset      (reset),
        .bus        (bus),
        .arm        (arm),
        .bp_en      (bp_en),
        .bp_pc      (bp_pc),
        .post_count (post_count),
        .state_out  (state_out),
        .count_out  (count_out),
        .triggered  (triggered)
    );

    typedef struct {
        string       name;
        bit          is_rd;
        logic        valid;
        logic [31:0] data;
        logic [1:0]  state;
        logic [4:0]  count;
        logic        trig;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per probe strobe and compares live outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge probe);
            #1;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL monitor: probe with empty scoreboard");
            end else begin
                e = sb_q.pop_front();
                if (e.is_rd) begin
                    check($sformatf("%s rd_valid", e.name), 32'(bus.rd_valid), 32'(e.valid));
                    check($sformatf("%s rd_data", e.name), bus.rd_data, e.data);
                end else begin
                    check($sformatf("%s state", e.name), 32'(state_out), 32'(e.state));
                    check($sformatf("%s count", e.name), 32'(count_out), 32'(e.count));
                    check($sformatf("%s triggered", e.name), 32'(triggered), 32'(e.trig));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        #1 hand_clock = 1'b1;
        #5 hand_clock = 1'b0;
        #4;
    endtask

    task automatic pulse_probe();
        probe = 1'b1;
        #2 probe = 1'b0;
        #1;
    endtask

    task automatic expect_rd(input string name, input logic [3:0] idx, input logic [1:0] sel,
                             input logic valid, input logic [31:0] data);
        exp_t e;
        e.name = name; e.is_rd = 1'b1; e.valid = valid; e.data = data;
        e.state = '0; e.count = '0; e.trig = 1'b0;
        bus.rd_idx = idx;
        bus.rd_sel = sel;
        sb_q.push_back(e);
        pulse_probe();
    endtask

    task automatic expect_st(input string name, input logic [1:0] st, input logic [4:0] cnt,
                             input logic trig);
        exp_t e;
        e.name = name; e.is_rd = 1'b0; e.valid = 1'b0; e.data = '0;
        e.state = st; e.count = cnt; e.trig = trig;
        sb_q.push_back(e);
        pulse_probe();
    endtask

    task automatic step(input logic [8:0] pc, input logic [31:0] instr, input logic we,
                        input logic [4:0] waddr, input logic [31:0] wdata);
        bus.pc_in        = pc;
        bus.instr_in     = instr;
        bus.reg_we_in    = we;
        bus.reg_waddr_in = waddr;
        bus.reg_wdata_in = wdata;
        arm = 1'b0;
        tick();
    endtask

    task automatic step_pc(input logic [8:0] pc);
        step(pc, 32'h1000_0000 + 32'(pc), 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        hand_clock = 1'b0; reset = 1'b0; arm = 1'b0; probe = 1'b0;
        bp_en = 1'b0; bp_pc = '0; post_count = '0;
        bus.pc_in = '0; bus.instr_in = '0; bus.reg_we_in = 1'b0;
        bus.reg_waddr_in = '0; bus.reg_wdata_in = '0;
        bus.rd_idx = '0; bus.rd_sel = '0;
        #1 reset = 1'b1;
        #2;
        expect_st("reset", 2'b00, 5'd0, 1'b0);
        expect_rd("reset rd", 4'd0, 2'b00, 1'b0, 32'd0);
        reset = 1'b0;
        #2;

        // Five steps after arm
        do_arm();
        expect_st("armed", 2'b01, 5'd0, 1'b0);
        for (int k = 0; k < 5; k++) step_pc(9'(4 * k));
        expect_st("five steps", 2'b01, 5'd5, 1'b0);
        expect_rd("newest pc", 4'd0, 2'b00, 1'b1, 32'd16);
        expect_rd("oldest pc", 4'd4, 2'b00, 1'b1, 32'd0);
        expect_rd("beyond count", 4'd5, 2'b00, 1'b0, 32'd0);
        expect_rd("instr idx1", 4'd1, 2'b01, 1'b1, 32'h1000_000C);

        // Wrap: 20 steps into 16 entries
        do_arm();
        for (int k = 0; k < 20; k++) step_pc(9'(4 * k));
        expect_st("wrap", 2'b01, 5'd16, 1'b0);
        expect_rd("wrap newest", 4'd0, 2'b00, 1'b1, 32'd76);
        expect_rd("wrap oldest", 4'd15, 2'b00, 1'b1, 32'd16);

        // Breakpoint at 0x20 with three post captures
        bp_en = 1'b1; bp_pc = 9'h020; post_count = 4'd3;
        do_arm();
        for (int k = 0; k <= 8; k++) step_pc(9'(4 * k));
        expect_st("trigger", 2'b10, 5'd9, 1'b1);
        step_pc(9'h024);
        step_pc(9'h028);
        expect_st("post", 2'b10, 5'd11, 1'b1);
        step_pc(9'h02C);
        expect_st("frozen", 2'b11, 5'd12, 1'b1);
        expect_rd("frozen newest", 4'd0, 2'b00, 1'b1, 32'h2C);
        expect_rd("trigger entry", 4'd3, 2'b00, 1'b1, 32'h20);
        for (int k = 12; k < 15; k++) step_pc(9'(4 * k));
        expect_st("frozen hold", 2'b11, 5'd12, 1'b1);
        expect_rd("frozen hold rd", 4'd0, 2'b00, 1'b1, 32'h2C);

        // Matches during POST do not reload the window
        bp_pc = 9'h008; post_count = 4'd2;
        do_arm();
        step_pc(9'h008);
        expect_st("retrig a", 2'b10, 5'd1, 1'b1);
        step_pc(9'h008);
        expect_st("retrig b", 2'b10, 5'd2, 1'b1);
        step_pc(9'h00C);
        expect_st("retrig c", 2'b11, 5'd3, 1'b1);

        // post_count 0 freezes on the trigger edge; arm beats a trigger
        bp_pc = 9'h040; post_count = 4'd0;
        do_arm();
        step_pc(9'h040);
        expect_st("pc0 freeze", 2'b11, 5'd1, 1'b1);
        expect_rd("pc0 entry", 4'd0, 2'b00, 1'b1, 32'h40);
        do_arm();
        step_pc(9'h040);
        expect_st("pc0 again", 2'b11, 5'd1, 1'b1);
        bus.pc_in = 9'h040;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        expect_st("arm priority", 2'b01, 5'd0, 1'b0);
        expect_rd("arm priority rd", 4'd0, 2'b00, 1'b0, 32'd0);

        // Asynchronous reset in the middle of POST
        bp_pc = 9'h010; post_count = 4'd3;
        do_arm();
        step_pc(9'h010);
        step_pc(9'h014);
        expect_st("pre reset post", 2'b10, 5'd2, 1'b1);
        reset = 1'b1;
        #1;
        expect_st("async reset", 2'b00, 5'd0, 1'b0);
        expect_rd("async reset rd", 4'd0, 2'b00, 1'b0, 32'd0);
        reset = 1'b0;
        bp_en = 1'b0;
        step_pc(9'h018);
        expect_st("idle hold", 2'b00, 5'd0, 1'b0);
        do_arm();
        expect_st("arm after reset", 2'b01, 5'd0, 1'b0);

        // Register-write fields: lw x5 then sw
        step(9'h100, 32'h0002_A283, 1'b1, 5'd5, 32'h0000_1234);
        step(9'h104, 32'h0053_2223, 1'b0, 5'd4, 32'h0000_DEAD);
        expect_rd("lw wdata", 4'd1, 2'b10, 1'b1, 32'h0000_1234);
        expect_rd("lw we/waddr", 4'd1, 2'b11, 1'b1, 32'h25);
        expect_rd("lw instr", 4'd1, 2'b01, 1'b1, 32'h0002_A283);
        expect_rd("lw pc", 4'd1, 2'b00, 1'b1, 32'h100);
        expect_rd("sw we/waddr", 4'd0, 2'b11, 1'b1, 32'h04);
        expect_rd("sw wdata", 4'd0, 2'b10, 1'b1, 32'h0000_DEAD);

        for (int i = 0; i < 100 && sb_q.size() != 0; i++) #1;
        while (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            errors++;
            $display("FAIL %s: never compared, expected entry left in scoreboard", e.name);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
